mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single cache/bypass memory port between up to NREQ requesters: CPU data port (req 0), frame filler (req 1) and line-engine command fetch (req 2).
- Round-robin arbitration with optional lock for multi-beat transfers and a lock-timeout watchdog.
- Fixed 1-cycle read latency on the memory port; read data is routed back to the requester that issued the read.
- Sits between the core/graphics masters and the Memory150 dcache/bypass ports, and honours the global stall.

Parameters:
NREQ, 3, number of requesters (2..4)
MAX_LOCK, 16, maximum consecutive granted cycles under lock before forced release
CPU_PRIO, 1, 1 = requester 0 wins ties over the round-robin pointer; 0 = pure round-robin

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stall  in  1  memory-system stall; freezes all arbiter state
req  in  NREQ  request per requester
lock  in  NREQ  hold grant after current beat while asserted
we  in  4*NREQ  byte write enables; 0 = read
addr  in  32*NREQ  byte address per requester
din  in  32*NREQ  write data per requester
gnt  out  NREQ  one-hot grant; beat accepted when req&gnt&~stall
rvalid  out  NREQ  read data valid, one-hot
rdata  out  32  read data, shared by all requesters
mem_addr  out  32  {4'b0, addr[27:2], 2'b0} of the granted requester
mem_we  out  4  we of the granted requester, gated by ~stall
mem_re  out  1  granted read, gated by ~stall
mem_din  out  32  din of the granted requester
mem_dout  in  32  memory read data, 1 cycle after mem_re
lock_err  out  1  sticky; set on lock timeout

Behaviour:
- Reset (rst low, asynchronous):
  - gnt=0, rvalid=0, rdata=0, lock_err=0.
  - RR pointer=0, lock counter=0, state=IDLE.
- States:
  - IDLE: no grant. A pending req moves to GRANT in the same cycle (grant is combinational from req and the pointer).
  - GRANT: one-hot gnt to the winner.
  - LOCKED: gnt held to the owner irrespective of other requests.
- Arbitration:
  - The winner is the first requester with req=1 searching from the pointer upward, modulo NREQ.
  - With CPU_PRIO=1, req[0] wins whenever asserted, except while another requester owns a lock.
- Beat acceptance and pointer update:
  - A beat is accepted when req[i]&gnt[i]&~stall.
  - After an unlocked accepted beat, the pointer moves to i+1 mod NREQ.
  - If lock[i]=1 on an accepted beat, the next state is LOCKED with owner i and the pointer unchanged.
- LOCKED:
  - Counter increments on every non-stalled cycle.
  - Owner drops lock, or drops req: return to IDLE/GRANT and advance the pointer past the owner.
  - Counter reaches MAX_LOCK: force release, set lock_err, advance the pointer.
  - Counter resets on entering LOCKED.
- Read return:
  - A registered tag captures the source id and read flag of the accepted beat.
  - Next non-stalled cycle: rvalid[tag]=1 and rdata=mem_dout.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
- Stall:
  - stall=1 freezes the pointer, state, counter, tag and rvalid/rdata (held).
  - mem_we and mem_re are forced to 0.
  - gnt remains combinationally visible but no beat is accepted.
- Simultaneous events:
  - Requester 1 drops req in the cycle it is granted: no beat; re-arbitrate next cycle.
  - Write and read from the same requester in consecutive cycles: accepted in order, with no hazard check (the memory is write-first).
- Reset mid-transfer: any in-flight read is dropped, with no rvalid.
- No combinational path from rvalid or rdata to gnt.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, GRANT, LOCKED)
  - the address-alignment mask
  - the function next_rr(req, ptr, cpu_prio) returning the one-hot winner
- One sub-module, rr_picker: combinational priority rotate, parameterised by NREQ.
- Counter, tag pipeline and FSM live in mem_port_arbiter.

Test Plan:
- Reset release, single read:
  - Stimulus: req=001, we0=0, addr0=0x10000008, mem_dout=0xDEADBEEF.
  - Required: mem_addr=0x00000008, mem_re=1 in cycle 0; rvalid=001, rdata=0xDEADBEEF in cycle 1.
- Round-robin fairness:
  - Stimulus: CPU_PRIO=0, req=111 held for 6 cycles.
  - Required: gnt sequence 001,010,100,001,010,100.
- CPU priority:
  - Stimulus: CPU_PRIO=1, req=110 for 2 cycles, then req=111.
  - Required: gnt=010,100,001.
- Lock and timeout:
  - Stimulus: MAX_LOCK=4, req1=lock1=1 held, req0=1.
  - Required: gnt=010 for 5 beats (the locking beat plus 4 under lock), then gnt=001 with lock_err=1 sticky.
- Stall freeze:
  - Stimulus: read accepted, then stall=1 for 3 cycles.
  - Required: mem_re=0 during stall; rvalid held 0; rvalid asserts the first cycle after stall falls, with the captured data.
- Async reset mid-read:
  - Stimulus: rst=0 asserted asynchronously one half-cycle after the read is accepted.
  - Required: rvalid=0, gnt=0 immediately; no rvalid after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, address mask
// and the round-robin winner selection.
package mem_arb_pkg;

    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned PTR_W   = 2;

    // Word-aligned address within the 256 MB memory window.
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0FFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] next_rr(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        nreq,
        input logic               cpu_prio
    );
        logic [MAX_REQ-1:0] win;
        logic [PTR_W-1:0]   idx;
        win = '0;
        if (cpu_prio && req[0]) begin
            win[0] = 1'b1;
        end else begin
            for (int unsigned k = 0; k < MAX_REQ; k++) begin
                idx = PTR_W'((32'(ptr) + k) % nreq);
                if (k < nreq && win == '0 && req[idx]) begin
                    win[idx] = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational rotate-priority picker: one-hot winner from requests and the
// round-robin pointer, with optional fixed priority for requester 0.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned CPU_PRIO = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req_i;
        gnt_o              = NREQ'(next_rr(req_ext, ptr_i, NREQ, CPU_PRIO != 0));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between NREQ masters: round-robin grant,
// lock with timeout watchdog, and 1-cycle read return routed by a tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MAX_LOCK = 16,
    parameter int unsigned CPU_PRIO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [4*NREQ-1:0]   we,
    input  logic [32*NREQ-1:0]  addr,
    input  logic [32*NREQ-1:0]  din,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [31:0]         rdata,
    output logic [31:0]         mem_addr,
    output logic [3:0]          mem_we,
    output logic                mem_re,
    output logic [31:0]         mem_din,
    input  logic [31:0]         mem_dout,
    output logic                lock_err
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_err_q, lock_err_d;
    logic             tag_vld_q, tag_vld_d;
    logic [PTR_W-1:0] tag_id_q, tag_id_d;
    logic             dat_held_q, dat_held_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [NREQ-1:0]  pick;
    logic [NREQ-1:0]  gnt_int;
    logic [PTR_W-1:0] win_idx;
    logic [3:0]       sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_din;
    logic             accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_picker #(
        .NREQ     (NREQ),
        .CPU_PRIO (CPU_PRIO)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        if (!rst) begin
            gnt_int = '0;
        end else if (state_q == ST_LOCKED) begin
            gnt_int = NREQ'(1) << owner_q;
        end else begin
            gnt_int = pick;
        end
    end

    always_comb begin
        win_idx  = '0;
        sel_we   = '0;
        sel_addr = '0;
        sel_din  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_int[i]) begin
                win_idx  = PTR_W'(i);
                sel_we   = we[4*i +: 4];
                sel_addr = addr[32*i +: 32];
                sel_din  = din[32*i +: 32];
            end
        end
    end

    assign accept   = (|(req & gnt_int)) & ~stall;
    assign gnt      = gnt_int;
    assign mem_we   = accept ? sel_we : 4'b0000;
    assign mem_re   = accept & ~(|sel_we);
    assign mem_addr = sel_addr & ADDR_ALIGN_MASK;
    assign mem_din  = sel_din;
    assign lock_err = lock_err_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        lock_err_d = lock_err_q;
        if (!stall) begin
            case (state_q)
                ST_LOCKED: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!req[owner_q] || !lock[owner_q]) begin
                        state_d = (|req) ? ST_GRANT : ST_IDLE;
                        ptr_d   = ptr_inc(owner_q);
                    end else if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                        state_d    = (|req) ? ST_GRANT : ST_IDLE;
                        ptr_d      = ptr_inc(owner_q);
                        lock_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = (|req) ? ST_GRANT : ST_IDLE;
                    if (accept) begin
                        if (|(lock & gnt_int)) begin
                            state_d = ST_LOCKED;
                            owner_d = win_idx;
                            cnt_d   = '0;
                        end else begin
                            ptr_d = ptr_inc(win_idx);
                        end
                    end
                end
            endcase
        end
    end

    // The memory drives read data only in the cycle after mem_re; if that
    // cycle is stalled the word is parked in rdata_q until the return fires.
    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_id_d   = tag_id_q;
        dat_held_d = dat_held_q;
        rdata_d    = rdata_q;
        if (tag_vld_q && !dat_held_q) begin
            rdata_d = mem_dout;
        end
        if (stall) begin
            if (tag_vld_q) begin
                dat_held_d = 1'b1;
            end
        end else begin
            tag_vld_d  = mem_re;
            tag_id_d   = win_idx;
            dat_held_d = 1'b0;
        end
    end

    assign rvalid = (tag_vld_q && !stall) ? (NREQ'(1) << tag_id_q) : '0;
    assign rdata  = (tag_vld_q && !dat_held_q) ? mem_dout : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_id_q   <= '0;
            dat_held_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            dat_held_q <= dat_held_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
